// File: rtl/mult_hilo_ctrl.sv
// Multiply sequencer and HI/LO register owner: launches the iterative multiplier,
// captures its 2*WIDTH product, services HI/LO moves and stalls the front end.
module mult_hilo_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mult_e,
  input  logic               mult_sign_e,
  input  logic               mfhi_d,
  input  logic               mflo_d,
  input  logic               mthi_d,
  input  logic               mtlo_d,
  input  logic               mthi_w,
  input  logic               mtlo_w,
  input  logic [WIDTH-1:0]   wdata_w,
  input  logic               mult_ready,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] product,
  output logic               start_mult,
  output logic               mult_sign,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               stall_mult,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    BUSY     = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [CW-1:0]     count_r, count_s;
  logic [WIDTH-1:0]  hi_r, hi_s;
  logic [WIDTH-1:0]  lo_r, lo_s;
  logic              mult_sign_r, mult_sign_nxt_s;
  logic              timeout_err_r, timeout_err_s;
  logic              start_s;
  logic              stall_s;
  logic              sign_out_s;
  logic              hilo_req_s;

  // Next-state, HI/LO write selection, start pulse and stall generation
  always_comb begin
    state_s         = state_r;
    count_s         = count_r;
    mult_sign_nxt_s = mult_sign_r;
    timeout_err_s   = timeout_err_r;
    start_s         = 1'b0;
    stall_s         = 1'b0;
    sign_out_s      = mult_sign_r;
    hilo_req_s      = mfhi_d | mflo_d | mthi_d | mtlo_d | mult_e;

    if (mthi_w) begin
      hi_s = wdata_w;
    end else begin
      hi_s = hi_r;
    end
    if (mtlo_w) begin
      lo_s = wdata_w;
    end else begin
      lo_s = lo_r;
    end

    case (state_r)
      IDLE: begin
        if (mult_e) begin
          if (mult_ready) begin
            // Present the new signedness alongside the start pulse
            start_s         = 1'b1;
            sign_out_s      = mult_sign_e;
            mult_sign_nxt_s = mult_sign_e;
            count_s         = '0;
            state_s         = BUSY;
          end else begin
            stall_s = 1'b1;
            state_s = WAIT_RDY;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT_RDY: begin
        stall_s    = 1'b1;
        sign_out_s = mult_sign_e;
        if (mult_ready) begin
          start_s         = 1'b1;
          mult_sign_nxt_s = mult_sign_e;
          count_s         = '0;
          state_s         = BUSY;
        end else begin
          state_s = WAIT_RDY;
        end
      end
      BUSY: begin
        stall_s = hilo_req_s;
        count_s = count_r + CW'(1);
        // Completion beats both a late MTHI/MTLO and the timeout point
        if (mult_done) begin
          hi_s    = product[2*WIDTH-1:WIDTH];
          lo_s    = product[WIDTH-1:0];
          state_s = IDLE;
        end else if (count_r == LAST_COUNT) begin
          timeout_err_s = 1'b1;
          state_s       = IDLE;
        end else begin
          state_s = BUSY;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counter, signedness, sticky error and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      count_r       <= '0;
      hi_r          <= '0;
      lo_r          <= '0;
      mult_sign_r   <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      count_r       <= count_s;
      hi_r          <= hi_s;
      lo_r          <= lo_s;
      mult_sign_r   <= mult_sign_nxt_s;
      timeout_err_r <= timeout_err_s;
    end
  end

  assign start_mult  = start_s & ~reset;
  assign stall_mult  = stall_s & ~reset;
  assign mult_sign   = sign_out_s & ~reset;
  assign busy        = (state_r != IDLE);
  assign hi          = hi_r;
  assign lo          = lo_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_mult_hilo_ctrl.sv
// Scenario bench for mult_hilo_ctrl: the bench plays the multiplier and keeps a
// scoreboard of expected HI/LO products.
module tb_mult_hilo_ctrl;

  localparam int WIDTH = 32;

  logic               clk;
  logic               reset;
  logic               mult_e, mult_sign_e;
  logic               mfhi_d, mflo_d, mthi_d, mtlo_d;
  logic               mthi_w, mtlo_w;
  logic [WIDTH-1:0]   wdata_w;
  logic               mult_ready, mult_done;
  logic [2*WIDTH-1:0] product;
  logic               start_mult, mult_sign, stall_mult, busy, timeout_err;
  logic [WIDTH-1:0]   hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [2*WIDTH-1:0] sb[$];
  logic [WIDTH-1:0]   cur_hi, cur_lo;

  mult_hilo_ctrl #(.WIDTH(WIDTH), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .mult_e(mult_e), .mult_sign_e(mult_sign_e),
    .mfhi_d(mfhi_d), .mflo_d(mflo_d), .mthi_d(mthi_d), .mtlo_d(mtlo_d),
    .mthi_w(mthi_w), .mtlo_w(mtlo_w), .wdata_w(wdata_w),
    .mult_ready(mult_ready), .mult_done(mult_done), .product(product),
    .start_mult(start_mult), .mult_sign(mult_sign), .hi(hi), .lo(lo),
    .stall_mult(stall_mult), .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a MULT into execute with the multiplier ready; expects an immediate start.
  task automatic issue(input logic sgn, input logic [2*WIDTH-1:0] prod, input bit push);
    mult_e = 1'b1; mult_sign_e = sgn; mult_ready = 1'b1;
    #1;
    n_vec++; if (start_mult !== 1'b1) begin n_err++; $display("FAIL issue_start: got %b want 1", start_mult); end
    n_vec++; if (stall_mult !== 1'b0) begin n_err++; $display("FAIL issue_stall: got %b want 0", stall_mult); end
    n_vec++; if (mult_sign !== sgn) begin n_err++; $display("FAIL issue_sign: got %b want %b", mult_sign, sgn); end
    if (push) sb.push_back(prod);
    tick();
    mult_e = 1'b0; mult_ready = 1'b0; mult_sign_e = ~sgn;
  endtask

  // Run the BUSY phase for lat cycles, pulse done on the last, then check HI/LO.
  task automatic complete(input logic sgn, input logic [2*WIDTH-1:0] prod, input int lat,
                          input bit mfhi, input bit collide, input bit hold_e);
    logic [2*WIDTH-1:0] exp;
    int bcyc;
    bcyc = 0;
    mult_ready = 1'b0; mfhi_d = mfhi; mult_e = hold_e;
    for (int i = 1; i <= lat; i++) begin
      if (i == lat) begin
        mult_done = 1'b1; product = prod;
        if (collide) begin mthi_w = 1'b1; wdata_w = 32'hDEAD_BEEF; end
      end
      #1;
      if (busy === 1'b1) bcyc++;
      n_vec++; if (start_mult !== 1'b0) begin n_err++; $display("FAIL busy_start cyc%0d: got %b want 0", i, start_mult); end
      n_vec++; if (stall_mult !== (mfhi | hold_e)) begin n_err++; $display("FAIL busy_stall cyc%0d: got %b want %b", i, stall_mult, mfhi | hold_e); end
      n_vec++; if (mult_sign !== sgn) begin n_err++; $display("FAIL busy_sign cyc%0d: got %b want %b", i, mult_sign, sgn); end
      tick();
    end
    mult_done = 1'b0; mthi_w = 1'b0; product = '0; mult_ready = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL done_busy: got %b want 0", busy); end
    n_vec++; if (stall_mult !== 1'b0) begin n_err++; $display("FAIL done_stall: got %b want 0", stall_mult); end
    n_vec++; if (bcyc !== lat) begin n_err++; $display("FAIL busy_cycles: got %0d want %0d", bcyc, lat); end
    n_vec++;
    if (sb.size() == 0) begin
      n_err++; $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      exp = sb.pop_front();
      if ({hi, lo} !== exp) begin n_err++; $display("FAIL hilo: got %h_%h want %h", hi, lo, exp); end
      cur_hi = exp[2*WIDTH-1:WIDTH]; cur_lo = exp[WIDTH-1:0];
    end
    mfhi_d = 1'b0;
    if (!hold_e) mult_e = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mult_e = 1'b0; mult_sign_e = 1'b0;
    mfhi_d = 1'b0; mflo_d = 1'b0; mthi_d = 1'b0; mtlo_d = 1'b0;
    mthi_w = 1'b0; mtlo_w = 1'b0; wdata_w = '0;
    mult_ready = 1'b1; mult_done = 1'b0; product = '0;
    #2;
    n_vec++; if (hi !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_vec++; if (lo !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (stall_mult !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall_mult); end
    n_vec++; if (start_mult !== 1'b0) begin n_err++; $display("FAIL reset_start: got %b want 0", start_mult); end
    n_vec++; if (mult_sign !== 1'b0) begin n_err++; $display("FAIL reset_sign: got %b want 0", mult_sign); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_tmo: got %b want 0", timeout_err); end
    cur_hi = '0; cur_lo = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_unsigned();
    issue(1'b0, 64'h0000_0001_FFFF_FFFE, 1'b1);
    complete(1'b0, 64'h0000_0001_FFFF_FFFE, 32, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_signed_mfhi();
    issue(1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
    complete(1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 8, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_not_ready();
    mult_e = 1'b1; mult_sign_e = 1'b1; mult_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (stall_mult !== 1'b1) begin n_err++; $display("FAIL nr_stall cyc%0d: got %b want 1", i, stall_mult); end
      n_vec++; if (start_mult !== 1'b0) begin n_err++; $display("FAIL nr_start cyc%0d: got %b want 0", i, start_mult); end
      n_vec++; if (busy !== (i != 0)) begin n_err++; $display("FAIL nr_busy cyc%0d: got %b want %b", i, busy, i != 0); end
      tick();
    end
    mult_ready = 1'b1;
    #1;
    n_vec++; if (start_mult !== 1'b1) begin n_err++; $display("FAIL nr_rise_start: got %b want 1", start_mult); end
    n_vec++; if (mult_sign !== 1'b1) begin n_err++; $display("FAIL nr_rise_sign: got %b want 1", mult_sign); end
    sb.push_back(64'h0000_0000_0000_0006);
    tick();
    mult_e = 1'b0; mult_sign_e = 1'b0;
    complete(1'b1, 64'h0000_0000_0000_0006, 5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_collision();
    issue(1'b0, 64'h1234_5678_9ABC_DEF0, 1'b1);
    complete(1'b0, 64'h1234_5678_9ABC_DEF0, 6, 1'b0, 1'b1, 1'b0);
    mthi_w = 1'b1; wdata_w = 32'hDEAD_BEEF;
    tick();
    mthi_w = 1'b0; #1;
    n_vec++; if (hi !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL idle_mthi_hi: got %h want deadbeef", hi); end
    n_vec++; if (lo !== cur_lo) begin n_err++; $display("FAIL idle_mthi_lo: got %h want %h", lo, cur_lo); end
    mthi_w = 1'b1; mtlo_w = 1'b1; wdata_w = 32'h0BAD_F00D;
    tick();
    mthi_w = 1'b0; mtlo_w = 1'b0; #1;
    n_vec++; if ({hi, lo} !== 64'h0BAD_F00D_0BAD_F00D) begin n_err++; $display("FAIL idle_both: got %h_%h want 0badf00d_0badf00d", hi, lo); end
    cur_hi = 32'h0BAD_F00D; cur_lo = 32'h0BAD_F00D;
  endtask

  task automatic test_timeout();
    int cnt;
    cnt = 0;
    issue(1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (busy !== 1'b1) break;
      cnt++;
      if (cnt == 1) begin
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
      end
      tick();
    end
    n_vec++; if (cnt !== 64) begin n_err++; $display("FAIL tmo_cycles: got %0d want 64", cnt); end
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got %b want 1", timeout_err); end
    n_vec++; if ({hi, lo} !== {cur_hi, cur_lo}) begin n_err++; $display("FAIL tmo_hilo: got %h_%h want %h_%h", hi, lo, cur_hi, cur_lo); end
    tick();
    issue(1'b1, 64'h0000_0002_0000_0003, 1'b1);
    complete(1'b1, 64'h0000_0002_0000_0003, 4, 1'b0, 1'b0, 1'b0);
    n_vec++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 64'h0000_0011_0000_0022, 1'b1);
    complete(1'b0, 64'h0000_0011_0000_0022, 5, 1'b0, 1'b0, 1'b1);
    issue(1'b1, 64'h0000_0033_0000_0044, 1'b1);
    complete(1'b1, 64'h0000_0033_0000_0044, 3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midop();
    tick();
    issue(1'b0, 64'h0, 1'b0);
    mfhi_d = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (stall_mult !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_mult); end
    n_vec++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL rst_hilo: got %h_%h want 0", hi, lo); end
    n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_tmo: got %b want 0", timeout_err); end
    tick();
    reset = 1'b0; mfhi_d = 1'b0;
    mult_done = 1'b1; product = 64'hCAFE_CAFE_CAFE_CAFE;
    tick();
    mult_done = 1'b0; product = '0;
    #1;
    n_vec++; if ({hi, lo} !== 64'h0) begin n_err++; $display("FAIL rst_nocapture: got %h_%h want 0", hi, lo); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed_mfhi();
    test_not_ready();
    test_collision();
    test_timeout();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mult_hilo_ctrl.md
Name: mult_hilo_ctrl

Overview:
- Sequences the iterative multiplier for MULT/MULTU instructions and owns the architectural HI/LO registers.
- Issues the start pulse when a multiply reaches execute, latches signedness, and captures the 2*WIDTH product on completion.
- Services MFHI/MFLO/MTHI/MTLO and raises a pipeline stall while a result is outstanding.
- Sits beside hazard_unit; the stall output is ORed into stall_f/stall_d and holds the execute register.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH bits each, the product is 2*WIDTH.
TIMEOUT, 64, maximum BUSY cycles before abort; counter width is clog2(TIMEOUT+1).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
mult_e  in  1  MULT/MULTU in execute this cycle, already gated by flush_e
mult_sign_e  in  1  1 = signed (MULT), 0 = unsigned (MULTU)
mfhi_d  in  1  MFHI in decode
mflo_d  in  1  MFLO in decode
mthi_d  in  1  MTHI in decode
mtlo_d  in  1  MTLO in decode
mthi_w  in  1  MTHI writeback strobe
mtlo_w  in  1  MTLO writeback strobe
wdata_w  in  WIDTH  data for mthi_w/mtlo_w
mult_ready  in  1  multiplier idle and able to accept start
mult_done  in  1  multiplier one-cycle completion pulse
product  in  2*WIDTH  multiplier result, valid while mult_done=1
start_mult  out  1  one-cycle start pulse to multiplier
mult_sign  out  1  signedness to multiplier, held for the whole op
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
stall_mult  out  1  hold F/D/E stages
busy  out  1  state != IDLE
timeout_err  out  1  sticky abort flag

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; hi=0, lo=0; start_mult=0; mult_sign=0; count=0; timeout_err=0. Reset mid-operation abandons the op; HI/LO are not updated.
- States: IDLE, WAIT_RDY, BUSY.
- IDLE:
  - mult_e & mult_ready: start_mult=1 combinationally this cycle; latch mult_sign<=mult_sign_e; count<=0; go to BUSY.
  - mult_e & !mult_ready: go to WAIT_RDY; stall_mult=1.
- WAIT_RDY:
  - stall_mult=1; mult_sign is driven from mult_sign_e.
  - When mult_ready=1: start_mult=1 that cycle; latch mult_sign; go to BUSY.
- BUSY:
  - count increments each cycle.
  - mult_done=1: hi<=product[2W-1:W], lo<=product[W-1:0]; go to IDLE.
  - count==TIMEOUT-1 without done: timeout_err<=1 (sticky until reset); go to IDLE; HI/LO unchanged.
  - If done and the timeout point coincide, done wins.
- Stall rule: stall_mult = (state==WAIT_RDY) | (busy & (mfhi_d|mflo_d|mthi_d|mtlo_d|mult_e)).
  - Stall stays asserted in the cycle mult_done arrives; it drops the following cycle, when hi/lo hold the new value.
  - A second mult_e in BUSY is held in execute, then issues from IDLE once done.
  - start_mult is never asserted while busy.
- HI/LO writes:
  - mthi_w writes hi; mtlo_w writes lo; both may assert together.
  - mult_done capture in the same cycle overrides mthi_w/mtlo_w, because the multiply is younger in program order.
- mult_sign stays constant from start until return to IDLE.
- Latency: start at cycle N; hi/lo are valid at N+k+1, where mult_done is seen at N+k.

Test Plan:
- Unsigned: mult_e=1, mult_sign_e=0, multiplier returns product=64'h0000_0001_FFFF_FFFE after 32 cycles -> start_mult pulses once; busy=1 for 32 cycles; hi=1, lo=FFFF_FFFE.
- Signed, with MFHI behind: MULT -3*5 (product=64'hFFFF_FFFF_FFFF_FFF1), mfhi_d=1 during BUSY -> stall_mult=1 through the done cycle and drops the next cycle; hi=FFFF_FFFF, lo=FFFF_FFF1; mult_sign=1 throughout.
- Not ready: mult_e=1 with mult_ready=0 for 3 cycles -> WAIT_RDY, stall_mult=1, no start; start_mult pulses in the cycle mult_ready rises.
- Done vs MTHI collision: mthi_w=1, wdata_w=32'hDEAD_BEEF, in the same cycle as mult_done with product=64'h1234_5678_9ABC_DEF0 -> hi=1234_5678, lo=9ABC_DEF0. Separately, mthi_w while IDLE -> hi=DEAD_BEEF.
- Timeout: mult_done never asserted, TIMEOUT=64 -> after 64 BUSY cycles, timeout_err=1 and state=IDLE, HI/LO unchanged; a following MULT completes normally with timeout_err still 1.
- Reset mid-op: assert reset 10 cycles into BUSY -> immediately busy=0, stall_mult=0, hi=lo=0, timeout_err=0; no capture occurs after reset deasserts.
